md_ctrl: RTL

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_pkg.sv | 31 +++
 rtl/md_compute.sv | 60 ++++++
 rtl/md_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, cycle counts.
package md_ctrl_pkg;

  localparam int         MD_DATA_W      = 32;
  localparam logic [3:0] MD_MULT_CYCLES = 4'd5;
  localparam logic [3:0] MD_DIV_CYCLES  = 4'd10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational product/quotient datapath; result is {hi, lo}.
module md_compute
  import md_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div0;
  logic               ovf;

  assign a_s    = a_i;
  assign b_s    = b_i;
  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign div0   = (b_i == 32'd0);
  // Most-negative / -1 overflows a 32-bit quotient; the defined result is handled explicitly.
  assign ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!div0 && !ovf) begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
    end
    if (!div0) begin
      quo_u = a_i / b_i;
      rem_u = a_i % b_i;
    end
  end

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV: begin
        if (div0)     res_o = {a_i, 32'hFFFF_FFFF};
        else if (ovf) res_o = {32'd0, 32'h8000_0000};
        else          res_o = {rem_s, quo_s};
      end
      MD_DIVU:  res_o = div0 ? {a_i, 32'hFFFF_FFFF} : {rem_u, quo_u};
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and D-stage stall.
// Optional MD_DIV0_HOLD_EN: divide by zero leaves HI/LO untouched instead of committing.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] res;
  logic        commit_ok;

  md_compute u_compute (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (res)
  );

`ifdef MD_DIV0_HOLD_EN
  assign commit_ok = !(md_is_div(op_q) && (b_q == 32'd0));
`else
  assign commit_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                cnt_q   <= md_is_div(md_op) ? MD_DIV_CYCLES : MD_MULT_CYCLES;
                op_q    <= md_op;
                a_q     <= A;
                b_q     <= B;
                state_q <= MD_BUSY;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          // start is deliberately ignored here; the stall keeps new ops out.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= MD_IDLE;
            if (commit_ok) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign stall = D_md_use & (busy | (start & md_is_long(md_op)));
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
